// File: rtl/alu_exec_if.sv
// Instruction handshake, ALU operand/result bus, status and debug port of the execute controller.
// slave is the controller's view; master is the surrounding environment (issuer + ALU).
interface alu_exec_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_o;
    logic              alu_z;
    logic              alu_c;
    logic              alu_n;
    logic              alu_v;
    logic [3:0]        flags;
    logic              done;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr, alu_o, alu_z, alu_c, alu_n, alu_v, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, flags, done, illegal, dbg_data
    );

    modport master (
        output instr_valid, instr, alu_o, alu_z, alu_c, alu_n, alu_v, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, flags, done, illegal, dbg_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Four-state execute controller around an external 16-bit ALU: fetch operands from a 16x16
// register file, drive the ALU, capture result and flags, write back.
module alu_exec_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input logic      clk,
    input logic      rst,
    alu_exec_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REG_AW;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flag_lat_q, flag_lat_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] rf_q [NumRegs];
    logic [DATA_W-1:0] rf_d [NumRegs];

    logic [REG_AW-1:0] rd, rs, rt;
    logic              is_ldi, is_illegal;
    logic [DATA_W-1:0] imm;

    assign rd         = instr_q[8 +: REG_AW];
    assign rs         = instr_q[4 +: REG_AW];
    assign rt         = instr_q[0 +: REG_AW];
    assign is_ldi     = instr_q[15] && (instr_q[14:12] == 3'b000);
    assign is_illegal = instr_q[15] && (instr_q[14:12] != 3'b000);
    assign imm        = {{(DATA_W - 8){1'b0}}, instr_q[7:0]};

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        flag_lat_d = flag_lat_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        rf_d       = rf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = StRead;
                end
            end
            StRead: begin
                op_a_d  = rf_q[rs];
                op_b_d  = rf_q[rt];
                state_d = StExec;
            end
            StExec: begin
                res_d      = bus.alu_o;
                flag_lat_d = {bus.alu_z, bus.alu_c, bus.alu_n, bus.alu_v};
                // done/illegal are registered, so they are raised here to appear during WB
                done_d     = 1'b1;
                illegal_d  = is_illegal;
                state_d    = StWb;
            end
            StWb: begin
                if (!instr_q[15]) begin
                    if (rd != '0) rf_d[rd] = res_q;
                    // flags load even for rd=0 so SUB to R0 works as a compare
                    flags_d = flag_lat_q;
                end else if (is_ldi && (rd != '0)) begin
                    rf_d[rd] = imm;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            flag_lat_q <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_q      <= res_d;
            flag_lat_q <= flag_lat_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            rf_q       <= rf_d;
        end
    end

    assign bus.instr_ready = (state_q == StIdle);
    assign bus.alu_a       = op_a_q;
    assign bus.alu_b       = op_b_q;
    assign bus.alu_op      = instr_q[14:12];
    assign bus.flags       = flags_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule
